// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side handshake and status bundle of the UART receiver.
//   rx_i_ready       consumer -> receiver : byte can be accepted
//   rx_o_data        receiver -> consumer : received byte (stable while valid)
//   rx_o_data_valid  receiver -> consumer : holding register is full
//   rx_o_frame_err   receiver -> consumer : 1-cycle pulse, stop bit was low
//   rx_o_overrun     receiver -> consumer : 1-cycle pulse, byte dropped (register full)
`timescale 1ns/1ps
interface uart_rx_if;
  logic       rx_i_ready;
  logic [7:0] rx_o_data;
  logic       rx_o_data_valid;
  logic       rx_o_frame_err;
  logic       rx_o_overrun;

  modport master (
    input  rx_i_ready,
    output rx_o_data, rx_o_data_valid, rx_o_frame_err, rx_o_overrun
  );

  modport slave (
    output rx_i_ready,
    input  rx_o_data, rx_o_data_valid, rx_o_frame_err, rx_o_overrun
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with centre sampling and a valid/ready holding register.
//   rx_clk   receive clock, all state changes on the rising edge
//   rx_rst   synchronous active-high reset
//   rx_en    receiver enable; low aborts any frame in progress
//   rx_i     asynchronous serial line, idle high
//   bus      uart_rx_if.master: rx_i_ready in; rx_o_data, rx_o_data_valid,
//            rx_o_frame_err, rx_o_overrun out
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic      rx_clk,
  input  logic      rx_rst,
  input  logic      rx_en,
  input  logic      rx_i,
  uart_rx_if.master bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_RELOAD = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_s_d;
  logic                   fall;
  logic [TW-1:0]          timer;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   commit_req;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;

  assign rx_s = sync[SYNC_STAGES-1];
  assign fall = rx_s_d & ~rx_s;

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      sync        <= '1;
      rx_s_d      <= 1'b1;
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      commit_req  <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], rx_i};
      rx_s_d      <= rx_s;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      commit_req  <= 1'b0;

      // Holding register: commit is one cycle after the good stop sample, so
      // shreg is still intact here even if a new start edge was just seen.
      if (commit_req) begin
        if (!valid_q || bus.rx_i_ready) begin
          data_q  <= shreg;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.rx_i_ready) begin
        valid_q <= 1'b0;
      end

      if (!rx_en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              timer <= HALF_RELOAD;
              state <= START;
            end
          end
          START: begin
            if (timer != '0) begin
              timer <= timer - TW'(1);
            end else if (rx_s) begin
              state <= IDLE;
            end else begin
              timer   <= FULL_RELOAD;
              bit_idx <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            if (timer != '0) begin
              timer <= timer - TW'(1);
            end else begin
              shreg[bit_idx] <= rx_s;
              timer          <= FULL_RELOAD;
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end
          STOP: begin
            if (timer != '0) begin
              timer <= timer - TW'(1);
            end else if (rx_s) begin
              commit_req <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            // A held-low line (break) must not look like a new start bit.
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_o_data       = data_q;
  assign bus.rx_o_data_valid = valid_q;
  assign bus.rx_o_frame_err  = frame_err_q;
  assign bus.rx_o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (16 clocks/bit, 2 sync stages).
`timescale 1ns/1ps
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic rxi;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut (
    .rx_clk (clk),
    .rx_rst (rst),
    .rx_en  (en),
    .rx_i   (rxi),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state, written only by the negedge monitor below.
  int         cyc = 0;
  int         rise_cnt = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vhigh_cnt = 0;
  int         stab_err = 0;
  int         excl_err = 0;
  int         last_rise_cyc = 0;
  logic [7:0] last_rise_data = '0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] prev_data = '0;

  // Stimulus-side bookkeeping.
  int         start_cyc;
  logic [7:0] rs_data;
  logic       rs_valid, rs_fe, rs_ov;
  int         r0, f0, o0, v0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_o_data_valid === 1'b1) vhigh_cnt++;
    if (bus.rx_o_data_valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cnt++;
      last_rise_cyc  = cyc;
      last_rise_data = bus.rx_o_data;
    end
    if (bus.rx_o_frame_err === 1'b1) fe_cnt++;
    if (bus.rx_o_overrun === 1'b1) ov_cnt++;
    if (bus.rx_o_frame_err === 1'b1 && bus.rx_o_overrun === 1'b1) excl_err++;
    if (prev_valid === 1'b1 && bus.rx_o_data_valid === 1'b1 && prev_ready !== 1'b1 &&
        prev_rst !== 1'b1 && bus.rx_o_data !== prev_data) stab_err++;
    prev_valid = bus.rx_o_data_valid;
    prev_ready = bus.rx_i_ready;
    prev_rst   = rst;
    prev_data  = bus.rx_o_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt; v0 = vhigh_cnt;
  endtask

  // One 8N1 frame, 16 steps per bit. Step k is driven #1 after an edge and is
  // sampled by the following edge. ready_k pulses rx_i_ready high for that one
  // step; en_k drops rx_en; rst_k pulses reset and aborts the frame (line idle).
  task automatic send_frame(input logic [7:0] b, input logic stopbit,
                            input int ready_k, input int en_k, input int rst_k);
    int bitn;
    start_cyc = cyc;
    for (int k = 0; k < 160; k++) begin
      bitn = k / 16;
      if (bitn == 0)      rxi = 1'b0;
      else if (bitn == 9) rxi = stopbit;
      else                rxi = b[bitn-1];
      if (k == ready_k) bus.rx_i_ready = 1'b1;
      else if (ready_k >= 0 && k == ready_k + 1) bus.rx_i_ready = 1'b0;
      if (k == en_k) en = 1'b0;
      if (k == rst_k) rst = 1'b1;
      if (rst_k >= 0 && k == rst_k + 1) begin
        rst      = 1'b0;
        rs_data  = bus.rx_o_data;
        rs_valid = bus.rx_o_data_valid;
        rs_fe    = bus.rx_o_frame_err;
        rs_ov    = bus.rx_o_overrun;
        rxi      = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rxi = 1'b1; bus.rx_i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(bus.rx_o_data), 32'h00);
    check("rst_valid", 32'(bus.rx_o_data_valid), 32'd0);
    check("rst_fe",    32'(bus.rx_o_frame_err), 32'd0);
    check("rst_ov",    32'(bus.rx_o_overrun), 32'd0);
    rst = 1'b0; en = 1'b1; bus.rx_i_ready = 1'b1;
    idle(20);

    // Nominal byte with ready held high
    snap();
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    idle(20);
    check("nom_data",   32'(last_rise_data), 32'hA5);
    check("nom_lat",    32'(last_rise_cyc - start_cyc - 1), 32'd155);
    check("nom_rises",  32'(rise_cnt - r0), 32'd1);
    check("nom_vhigh",  32'(vhigh_cnt - v0), 32'd1);
    check("nom_status", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

    // Back-to-back with backpressure: second byte overruns
    bus.rx_i_ready = 1'b0;
    snap();
    send_frame(8'h55, 1'b1, -1, -1, -1);
    send_frame(8'h19, 1'b1, -1, -1, -1);
    idle(20);
    check("bp_data",  32'(bus.rx_o_data), 32'h55);
    check("bp_valid", 32'(bus.rx_o_data_valid), 32'd1);
    check("bp_ov",    32'(ov_cnt - o0), 32'd1);
    bus.rx_i_ready = 1'b1;
    idle(1);
    check("bp_drain", 32'(bus.rx_o_data_valid), 32'd0);
    bus.rx_i_ready = 1'b0;
    idle(10);

    // Accept in the exact commit cycle of the next byte
    send_frame(8'h3C, 1'b1, -1, -1, -1);
    idle(20);
    check("sim_hold", 32'(bus.rx_o_data), 32'h3C);
    snap();
    send_frame(8'hC3, 1'b1, 155, -1, -1);
    idle(20);
    check("sim_data",  32'(bus.rx_o_data), 32'hC3);
    check("sim_valid", 32'(bus.rx_o_data_valid), 32'd1);
    check("sim_ov",    32'(ov_cnt - o0), 32'd0);
    bus.rx_i_ready = 1'b1;
    idle(1);
    bus.rx_i_ready = 1'b0;
    check("sim_drain", 32'(bus.rx_o_data_valid), 32'd0);

    // Frame error then 40-bit-time break
    bus.rx_i_ready = 1'b1;
    snap();
    send_frame(8'hFF, 1'b0, -1, -1, -1);
    idle(640);
    check("fe_pulses", 32'(fe_cnt - f0), 32'd1);
    check("fe_rises",  32'(rise_cnt - r0), 32'd0);
    check("fe_valid",  32'(bus.rx_o_data_valid), 32'd0);
    rxi = 1'b1;
    idle(40);
    send_frame(8'h81, 1'b1, -1, -1, -1);
    idle(20);
    check("fe_next_data",  32'(last_rise_data), 32'h81);
    check("fe_next_rises", 32'(rise_cnt - r0), 32'd1);
    check("fe_next_fe",    32'(fe_cnt - f0), 32'd1);

    // False start glitch
    snap();
    rxi = 1'b0;
    idle(5);
    rxi = 1'b1;
    idle(40);
    check("glitch_rises",  32'(rise_cnt - r0), 32'd0);
    check("glitch_status", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);
    send_frame(8'h0F, 1'b1, -1, -1, -1);
    idle(20);
    check("glitch_next_data",  32'(last_rise_data), 32'h0F);
    check("glitch_next_rises", 32'(rise_cnt - r0), 32'd1);

    // Enable dropped during data bit 3
    snap();
    send_frame(8'hAA, 1'b1, -1, 70, -1);
    idle(20);
    en = 1'b1;
    idle(20);
    send_frame(8'h42, 1'b1, -1, -1, -1);
    idle(20);
    check("en_rises",  32'(rise_cnt - r0), 32'd1);
    check("en_data",   32'(last_rise_data), 32'h42);
    check("en_status", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

    // Reset mid-frame with a byte held
    bus.rx_i_ready = 1'b0;
    send_frame(8'h5A, 1'b1, -1, -1, -1);
    idle(20);
    check("rstm_hold", 32'(bus.rx_o_data_valid), 32'd1);
    send_frame(8'h99, 1'b1, -1, -1, 80);
    check("rstm_data",  32'(rs_data), 32'h00);
    check("rstm_valid", 32'(rs_valid), 32'd0);
    check("rstm_fe",    32'(rs_fe), 32'd0);
    check("rstm_ov",    32'(rs_ov), 32'd0);
    idle(40);
    bus.rx_i_ready = 1'b1;
    snap();
    send_frame(8'h24, 1'b1, -1, -1, -1);
    idle(20);
    check("rstm_next_data",  32'(last_rise_data), 32'h24);
    check("rstm_next_rises", 32'(rise_cnt - r0), 32'd1);

    check("data_stable",  32'(stab_err), 32'd0);
    check("status_excl",  32'(excl_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the UART controller; sits directly downstream of uart_tx on the serial line.
- Synchronises the asynchronous serial input and detects 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Samples each bit at its centre using a clock-count oversampling timer.
- Presents each received byte on a valid/ready holding register, with frame-error and overrun status pulses.

Parameters:
- CLKS_PER_BIT, 16, rx_clk cycles per serial bit; must be even and >= 4.
- SYNC_STAGES, 2, flip-flop stages on rx_i before use; must be >= 2.

Ports:
- rx_clk  input  1  receive clock; all state updates on rising edge.
- rx_rst  input  1  synchronous, active-high reset.
- rx_en  input  1  receiver enable; low forces the FSM to IDLE.
- rx_i  input  1  serial line, idle high, asynchronous to rx_clk.
- rx_i_ready  input  1  downstream consumer can accept the byte.
- rx_o_data  output  8  received byte, stable while rx_o_data_valid=1.
- rx_o_data_valid  output  1  holding register holds an unconsumed byte.
- rx_o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- rx_o_overrun  output  1  one-cycle pulse: new byte dropped because the holding register was full.

Behaviour:
- Reset (rx_rst=1 at a clock edge):
  - FSM goes to IDLE; counters are cleared.
  - Synchroniser flops preset to 1.
  - rx_o_data=8'h00; rx_o_data_valid=0; rx_o_frame_err=0; rx_o_overrun=0.
  - Reset mid-frame discards the partial byte. The holding register is also cleared.
- Synchroniser: rx_s is the output of the SYNC_STAGES flop chain. rx_s_d is its one-cycle delayed copy. A falling edge is rx_s_d=1 and rx_s=0.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on a falling edge with rx_en=1, load the bit timer with CLKS_PER_BIT/2-1 and go to START.
  - START: the timer counts down to 0; at 0, sample rx_s.
    - If rx_s=1 (glitch/false start), go to IDLE with no status pulse.
    - If rx_s=0, reload the timer with CLKS_PER_BIT-1, clear the bit index, go to DATA.
  - DATA: at each timer expiry, shift rx_s into the shift register at bit position bit_index (LSB first) and reload the timer. After index 7, go to STOP.
  - STOP: at timer expiry, sample rx_s.
    - If rx_s=1, the frame is good: go to IDLE and raise the commit request.
    - If rx_s=0, pulse rx_o_frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering the receiver.
- Bit timer width is $clog2(CLKS_PER_BIT). It never wraps: it is always reloaded at 0.
- Commit (the cycle after a good stop-bit sample):
  - If rx_o_data_valid=0, or rx_i_ready=1 in that same cycle: load rx_o_data and set rx_o_data_valid=1. Same-cycle accept plus load keeps valid high with the new byte.
  - Otherwise: pulse rx_o_overrun for 1 cycle, drop the new byte, keep the old byte and valid unchanged.
- Handshake:
  - A transfer occurs on any edge where rx_o_data_valid=1 and rx_i_ready=1.
  - After a transfer with no same-cycle commit, valid drops to 0 on the next cycle.
  - rx_o_data must not change while valid=1 except at a transfer.
- Latency: rx_o_data_valid rises exactly SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 rx_clk edges after the first edge that samples rx_i low. This is 155 cycles for the defaults.
- rx_en:
  - Deassertion at any time forces IDLE on the next edge and discards the partial frame, with no status pulse.
  - The holding register and handshake keep operating while rx_en=0.
  - The falling-edge detector stays live while rx_en=0, but IDLE ignores edges then.
- Status pulses are never asserted simultaneously: frame error and commit are mutually exclusive per frame.

Test Plan:
- Nominal byte: reset, rx_en=1, rx_i_ready=1, drive 8'hA5 8N1 at 16 clocks/bit → rx_o_data=8'hA5, valid high for exactly 1 cycle, 155 cycles after the start edge; no status pulses.
- Back-to-back and backpressure: send 8'h55 then 8'h19 with rx_i_ready=0 → 8'h55 is held with valid=1. The 8'h19 commit pulses rx_o_overrun once and data stays 8'h55. Raise rx_i_ready → valid drops the next cycle.
- Simultaneous accept and commit: hold 8'h3C with rx_i_ready=0; assert rx_i_ready exactly in the commit cycle of 8'hC3 → no overrun, rx_o_data=8'hC3, valid stays 1.
- Framing/break: send 8'hFF with the stop bit low, then hold rx_i low for 40 bit times → single rx_o_frame_err pulse, valid stays 0, no new frame until the line returns high. The next 8'h81 is received correctly.
- False start: 5-cycle low glitch on idle rx_i → FSM returns to IDLE, no valid, no status pulse; a following 8'h0F is received correctly.
- Reset/enable mid-frame: drop rx_en at data bit 3 of 8'hAA, re-enable, send 8'h42 → only 8'h42 is delivered. Repeat with rx_rst pulsed mid-frame → all outputs 0 the next cycle.
